// File: rtl/sc_sched_ctrl_pkg.sv
// Shared definitions for the SC schedule controller and the process unit.
// Opcode values, instruction field layout and the default tree depth.
package sc_sched_ctrl_pkg;

    localparam int N_LOG_DEF = 3;
    localparam int OP_W      = 2;

    typedef enum logic [1:0] {
        OP_F    = 2'b00,
        OP_G    = 2'b01,
        OP_COMB = 2'b10,
        OP_LEAF = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_LEAF,
        S_COMB,
        S_DONE
    } state_e;

    function automatic int stg_w_f(int n_log);
        return (n_log <= 1) ? 1 : $clog2(n_log);
    endfunction

    // inst = {op, stage, leaf}; leaf sits at bit 0
    function automatic int stg_lsb_f(int n_log);
        return n_log;
    endfunction

    function automatic int op_lsb_f(int n_log);
        return n_log + stg_w_f(n_log);
    endfunction

    function automatic int inst_w_f(int n_log);
        return OP_W + stg_w_f(n_log) + n_log;
    endfunction

endpackage

// File: rtl/sc_sched_ctrl_tz_count.sv
// Combinational trailing-zero counter; an all-zero input yields N_LOG.
module tz_count #(
    parameter int N_LOG = 3,
    parameter int STG_W = 2
) (
    input  logic [N_LOG-1:0] i_val,
    output logic [STG_W:0]   o_cnt
);

    always_comb begin
        o_cnt = (STG_W+1)'(N_LOG);
        for (int k = N_LOG - 1; k >= 0; k--) begin
            if (i_val[k]) o_cnt = (STG_W+1)'(k);
        end
    end

endmodule

// File: rtl/sc_sched_ctrl.sv
// Successive-cancellation schedule controller: walks the SC tree and
// issues F/G/COMB/LEAF instructions, forming bit decisions at leaves.
module sc_sched_ctrl
    import sc_sched_ctrl_pkg::*;
#(
    parameter int N_LOG  = N_LOG_DEF,
    parameter int STG_W  = stg_w_f(N_LOG),
    parameter int INST_W = OP_W + STG_W + N_LOG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [(1<<N_LOG)-1:0] frozen,
    output logic                busy,
    output logic                done,
    output logic                inst_valid,
    output logic [INST_W-1:0]   inst,
    input  logic                pu_ready,
    input  logic                llr_sign,
    output logic [(1<<N_LOG)-1:0] u_hat
);

    localparam int N = 1 << N_LOG;

    state_e             r_state;
    op_e                r_op;
    logic [STG_W-1:0]   r_stg;
    logic [N_LOG-1:0]   r_i;
    logic [N-1:0]       r_frozen;
    logic [N-1:0]       r_u_hat;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_acc;
    logic               w_last;
    logic               w_comb_end;
    logic [N_LOG-1:0]   w_i_inc;
    logic [STG_W:0]     w_tz;

    assign w_acc   = r_valid & pu_ready;
    assign w_last  = &r_i;
    assign w_i_inc = r_i + N_LOG'(1);

    tz_count #(
        .N_LOG (N_LOG),
        .STG_W (STG_W)
    ) u_tz (
        .i_val (w_i_inc),
        .o_cnt (w_tz)
    );

    // combining stops one stage below where the next G is issued
    assign w_comb_end = ({1'b0, r_stg} == (w_tz - (STG_W+1)'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_F;
            r_stg    <= '0;
            r_i      <= '0;
            r_frozen <= '0;
            r_u_hat  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frozen <= frozen;
                        r_u_hat  <= '0;
                        r_i      <= '0;
                        r_stg    <= STG_W'(N_LOG - 1);
                        r_op     <= OP_F;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_DESC;
                    end
                end
                S_DESC: begin
                    if (w_acc) begin
                        if (r_stg == '0) begin
                            r_op    <= OP_LEAF;
                            r_state <= S_LEAF;
                        end else begin
                            r_stg <= r_stg - STG_W'(1);
                            r_op  <= OP_F;
                        end
                    end
                end
                S_LEAF: begin
                    if (w_acc) begin
                        r_u_hat[r_i] <= ~r_frozen[r_i] & llr_sign;
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_tz == '0) begin
                            r_i     <= w_i_inc;
                            r_op    <= OP_G;
                            r_stg   <= '0;
                            r_state <= S_DESC;
                        end else begin
                            r_op    <= OP_COMB;
                            r_stg   <= '0;
                            r_state <= S_COMB;
                        end
                    end
                end
                S_COMB: begin
                    if (w_acc) begin
                        if (w_comb_end) begin
                            r_i     <= w_i_inc;
                            r_op    <= OP_G;
                            r_stg   <= w_tz[STG_W-1:0];
                            r_state <= S_DESC;
                        end else begin
                            r_stg <= r_stg + STG_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign inst_valid = r_valid;
    assign inst       = {r_op, r_stg, r_i};
    assign u_hat      = r_u_hat;

endmodule

// File: tb/tb_sc_sched_ctrl.sv
// Self-checking bench for sc_sched_ctrl: vector table, random blocks
// against a per-leaf schedule model, reset abort and N_LOG=1 corner.
module tb_sc_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start;
    logic [7:0] frozen;
    logic       busy;
    logic       done;
    logic       inst_valid;
    logic [6:0] inst;
    logic       pu_ready;
    logic       llr_sign;
    logic [7:0] u_hat;

    logic       start1;
    logic [1:0] frozen1;
    logic       busy1;
    logic       done1;
    logic       inst_valid1;
    logic [3:0] inst1;
    logic       pu_ready1;
    logic       llr_sign1;
    logic [1:0] u_hat1;

    int pass_cnt = 0;
    int total_cnt = 0;

    int exp_q[$];
    int got_q[$];

    typedef struct {
        logic [7:0] fz;
        int         smode;
        int         rmode;
        logic [7:0] exp_uh;
    } vec_t;

    vec_t vecs[6];
    int   first15[15];
    int   exp1[4];

    always #5 clk = ~clk;

    sc_sched_ctrl #(.N_LOG(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frozen     (frozen),
        .busy       (busy),
        .done       (done),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pu_ready   (pu_ready),
        .llr_sign   (llr_sign),
        .u_hat      (u_hat)
    );

    sc_sched_ctrl #(.N_LOG(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .frozen     (frozen1),
        .busy       (busy1),
        .done       (done1),
        .inst_valid (inst_valid1),
        .inst       (inst1),
        .pu_ready   (pu_ready1),
        .llr_sign   (llr_sign1),
        .u_hat      (u_hat1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    function automatic int ctz(int x);
        int n = 0;
        while (x % 2 == 0) begin
            x = x / 2;
            n++;
        end
        return n;
    endfunction

    function automatic int enc(int op, int stg, int leaf);
        return op * 32 + stg * 8 + leaf;
    endfunction

    // Leaf i>0 needs: combine the finished left subtree of size 2^ctz(i),
    // one G at that level, then F down to the leaf.
    task automatic build_sched();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                for (int s = 2; s >= 0; s--) exp_q.push_back(enc(0, s, 0));
            end else begin
                int t = ctz(i);
                for (int s = 0; s < t; s++) exp_q.push_back(enc(2, s, i - 1));
                exp_q.push_back(enc(1, t, i));
                for (int s = t - 1; s >= 0; s--) exp_q.push_back(enc(0, s, i));
            end
            exp_q.push_back(enc(3, 0, i));
        end
    endtask

    task automatic run_block(input logic [7:0] fz, input int smode,
                             input int rmode, input int abort_after,
                             output logic [7:0] uh_model);
        int k = 0;
        int c = 1;
        int nleaf = 0;
        int leaf;
        logic [6:0] prev = '0;
        logic stalled = 1'b0;
        logic got_done = 1'b0;
        logic [7:0] um = '0;
        logic s;
        build_sched();
        got_q.delete();
        uh_model = '0;
        @(negedge clk);
        start = 1'b1;
        frozen = fz;
        pu_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        frozen = ~fz;
        while (!got_done && c < 400) begin
            if (k == exp_q.size()) begin
                chk("done_pulse", 32'(done), 1);
                chk("busy_at_done", 32'(busy), 0);
                chk("valid_at_done", 32'(inst_valid), 0);
                chk("u_hat_model", 32'(u_hat), 32'(um));
                if (rmode == 0) chk("done_cycle", c, 27);
                chk("inst_count", k, 26);
                got_done = 1'b1;
            end else begin
                chk("done_low", 32'(done), 0);
                chk("inst_valid", 32'(inst_valid), 1);
                chk("busy_high", 32'(busy), 1);
                if (stalled) chk("stall_hold", 32'(inst), 32'(prev));
                llr_sign = 1'($urandom_range(0, 1));
                pu_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (inst_valid && pu_ready) begin
                    chk("inst", 32'(inst), exp_q[k]);
                    got_q.push_back(int'(inst));
                    if (exp_q[k] / 32 == 3) begin
                        leaf = exp_q[k] % 8;
                        if (smode == 0) s = 1'b1;
                        else if (smode == 1) s = 1'(nleaf % 2);
                        else s = 1'($urandom_range(0, 1));
                        llr_sign = s;
                        um[leaf] = fz[leaf] ? 1'b0 : s;
                        nleaf++;
                    end
                    k++;
                    stalled = 1'b0;
                    if (abort_after != 0 && k == abort_after) begin
                        @(posedge clk);
                        #2 rst_n = 1'b0;
                        #1;
                        chk("rst_busy", 32'(busy), 0);
                        chk("rst_valid", 32'(inst_valid), 0);
                        chk("rst_inst", 32'(inst), 0);
                        chk("rst_u_hat", 32'(u_hat), 0);
                        for (int r = 0; r < 3; r++) begin
                            @(negedge clk);
                            chk("rst_no_done", 32'(done), 0);
                        end
                        rst_n = 1'b1;
                        pu_ready = 1'b0;
                        return;
                    end
                end else begin
                    stalled = inst_valid;
                end
                prev = inst;
            end
            if (!got_done) begin
                @(negedge clk);
                c++;
            end
        end
        if (!got_done) chk("timeout", 0, 1);
        pu_ready = 1'b0;
        uh_model = um;
    endtask

    initial begin
        logic [7:0] uh;
        logic [7:0] held;

        vecs[0] = '{8'h0F, 0, 0, 8'hF0};
        vecs[1] = '{8'h00, 1, 0, 8'hAA};
        vecs[2] = '{8'hFF, 0, 1, 8'h00};
        vecs[3] = '{8'h00, 0, 0, 8'hFF};
        vecs[4] = '{8'hA5, 1, 1, 8'h0A};
        vecs[5] = '{8'h3C, 0, 1, 8'hC3};

        first15 = '{16, 8, 0, 96, 33, 97, 65, 42, 2, 98, 35, 99, 67, 75, 52};
        exp1 = '{4'b0000, 4'b1100, 4'b0101, 4'b1101};

        rst_n = 1'b0;
        start = 1'b0;
        frozen = '0;
        pu_ready = 1'b0;
        llr_sign = 1'b0;
        start1 = 1'b0;
        frozen1 = '0;
        pu_ready1 = 1'b0;
        llr_sign1 = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_valid", 32'(inst_valid), 0);
        chk("reset_inst", 32'(inst), 0);
        chk("reset_u_hat", 32'(u_hat), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", 32'(inst_valid), 0);

        for (int v = 0; v < 6; v++) begin
            run_block(vecs[v].fz, vecs[v].smode, vecs[v].rmode, 0, uh);
            chk("vec_u_hat", 32'(u_hat), 32'(vecs[v].exp_uh));
            if (v == 0) begin
                for (int j = 0; j < 15; j++)
                    chk("first15", got_q.size() > j ? got_q[j] : -1,
                        first15[j]);
            end
        end

        for (int r = 0; r < 6; r++) begin
            run_block(8'($urandom), 2, 1, 0, uh);
            chk("rand_u_hat", 32'(u_hat), 32'(uh));
        end

        held = u_hat;
        repeat (3) @(negedge clk);
        chk("u_hat_hold_idle", 32'(u_hat), 32'(held));

        run_block(8'h0F, 0, 0, 10, uh);
        run_block(8'h0F, 0, 0, 0, uh);
        chk("after_rst_first", got_q.size() > 0 ? got_q[0] : -1, 16);
        chk("after_rst_u_hat", 32'(u_hat), 32'hF0);

        @(negedge clk);
        start1 = 1'b1;
        frozen1 = 2'b01;
        pu_ready1 = 1'b1;
        llr_sign1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        frozen1 = 2'b10;
        for (int c = 1; c <= 4; c++) begin
            chk("n1_valid", 32'(inst_valid1), 1);
            chk("n1_busy", 32'(busy1), 1);
            chk("n1_inst", 32'(inst1), exp1[c-1]);
            start1 = (c == 2);
            @(negedge clk);
        end
        chk("n1_done", 32'(done1), 1);
        chk("n1_busy_done", 32'(busy1), 0);
        chk("n1_u_hat", 32'(u_hat1), 32'h2);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_done_start_ign", 32'(busy1), 0);
        chk("n1_idle_valid", 32'(inst_valid1), 0);
        chk("n1_done_once", 32'(done1), 0);
        @(negedge clk);
        chk("n1_still_idle", 32'(busy1), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sc_sched_ctrl.md
# sc_sched_ctrl

Successive-cancellation schedule controller for the polar decoder. It walks the SC decoding tree for a block of N = 2^N_LOG bits and issues one F / G / COMBINE / LEAF instruction per accepted cycle to the process unit. At each leaf it forms the bit decision from the frozen mask and the process unit's leaf-LLR sign. It sits between the decoder top-level start/done handshake and the process unit instruction port.

## Interface
- N_LOG, default 3: log2 of block length N; legal range 1..8.
- STG_W, default clog2(N_LOG) (minimum 1): stage field width.
- INST_W, default 2+STG_W+N_LOG: instruction width.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle request; honoured only while idle.
- frozen  in  N  frozen mask; bit i = leaf i frozen; sampled on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse; u_hat valid from this cycle until the next accepted start.
- inst_valid  out  1  instruction on inst is valid.
- inst  out  INST_W  {opcode[1:0], stage[STG_W-1:0], leaf[N_LOG-1:0]}.
- pu_ready  in  1  process unit accepts inst this cycle.
- llr_sign  in  1  sign of leaf LLR (1 = negative); sampled when a LEAF instruction is accepted.
- u_hat  out  N  decided bits; bit i = leaf i.

## Operation
- Opcodes: F=2'b00, G=2'b01, COMB=2'b10, LEAF=2'b11. Stage 0 is next to the leaves; stage N_LOG-1 is next to the channel LLRs.
- ctz(x) is the trailing-zero count of x.
- The leaf field carries the current leaf index i for every opcode.
- Accept means inst_valid & pu_ready. The FSM, counters and inst advance only on accept.
- IDLE:
  - start → latch frozen, i=0, stg=N_LOG-1, op=F → DESCEND.
  - start is ignored in every other state.
- DESCEND: issue op at stg.
  - On accept with stg==0 → LEAF.
  - On accept otherwise → stg--, op=F.
- LEAF: issue LEAF at stage 0.
  - On accept: u_hat[i] = frozen[i] ? 0 : llr_sign.
  - If i==N-1 → DONE.
  - Else if ctz(i+1)==0 → i++, op=G, stg=0 → DESCEND.
  - Else → stg=0 → COMBINE.
- COMBINE: issue COMB at stg.
  - On accept with stg==ctz(i+1)-1 → i++, op=G, stg=ctz(i+1) (computed with the old i) → DESCEND.
  - On accept otherwise → stg++.
- DONE: done=1 and busy=0 for one cycle → IDLE.
- Instruction counts per block: 2N-2 F/G, N LEAF, sum over k=1..N-1 of ctz(k) COMB. For N=8 that is 14+8+4 = 26.
- u_hat is cleared on accepted start.

## Timing
- Reset values: busy=0, done=0, inst_valid=0, inst=0, u_hat=0, FSM=IDLE, all counters 0.
- Outputs are registered; inst and inst_valid come straight from flops.
- Start accepted at cycle t0: first instruction valid at t0+1.
- With pu_ready held high, one instruction per cycle. For N=8: last LEAF at t0+26, done at t0+27.
- Stall: while pu_ready=0, inst and inst_valid stay stable, and u_hat and the counters hold.
- inst_valid=0 in IDLE and DONE.
- Reset asserted mid-run: all state returns to reset values immediately. No done pulse. The next start begins a fresh block.
- start in the DONE cycle is ignored. A new start is accepted from the following cycle (IDLE).

## Structure
- Add the opcode constants, INST field positions and N_LOG default to the shared defines include. The process unit decodes the same opcode values.
- Sub-module tz_count: combinational trailing-zero counter, N_LOG-bit in, STG_W+1-bit out. Instantiate it on i+1.
- FSM, stage counter, leaf counter and u_hat register live in sc_sched_ctrl.

## Test plan
- N_LOG=3, pu_ready=1, start → the first 15 instructions are (op,stage,leaf): F2,0 F1,0 F0,0 LEAF0,0 G0,1 LEAF0,1 COMB0,1 G1,2 F0,2 LEAF0,2 G0,3 LEAF0,3 COMB0,3 COMB1,3 G2,4. The full block has 26 instructions and done at t0+27.
- frozen=8'b0000_1111, llr_sign=1 constant → u_hat=8'b1111_0000 at done.
- frozen=0, llr_sign toggling per accepted LEAF starting at 0 → u_hat=8'b1010_1010.
- pu_ready pseudo-random at 50% → same 26-instruction sequence, inst stable during every stall, done one cycle after the final LEAF accept.
- rst_n pulsed low after the 10th accept, then a new start → busy/inst_valid drop asynchronously, no done pulse, fresh sequence from F2,0.
- N_LOG=1 → F0,0 LEAF0,0 G0,1 LEAF0,1, done at t0+5. A start pulsed while busy is ignored.
